// File: rtl/wb_trace_fifo_if.sv
// Bundles the W-stage capture inputs and the serialized output stream of wb_trace_fifo.
// The slave modport is the trace block; the master modport is the pipeline plus the consumer.
interface wb_trace_fifo_if;
    logic        wb_en;
    logic [31:0] wb_pc;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport slave (
        input  wb_en, wb_pc, wb_addr, wb_data, out_ready,
        output out_valid, out_data, out_last
    );

    modport master (
        output wb_en, wb_pc, wb_addr, wb_data, out_ready,
        input  out_valid, out_data, out_last
    );
endinterface

// File: rtl/wb_trace_fifo.sv
// Writeback trace capture: buffers retired GRF writes as {pc, addr, data} records and
// streams each record as three 32-bit words. The pipeline is never stalled by this block.
module wb_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    wb_trace_fifo_if.slave           bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } rec_t;

    rec_t              mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [4:0]        hold_addr_q, hold_addr_d;
    logic [31:0]       hold_data_q, hold_data_d;

    logic evt, full, empty, push, drop, pop;
    rec_t wr_rec, rd_rec;

    // Fullness is judged on the count at the start of the cycle, so a same-cycle pop never rescues an event.
    always_comb begin
        evt    = bus.wb_en && (bus.wb_addr != 5'd0);
        full   = (count_q == CW'(DEPTH));
        empty  = (count_q == '0);
        push   = evt && !full;
        drop   = evt && full;
        wr_rec = '{pc: bus.wb_pc, addr: bus.wb_addr, data: bus.wb_data};
        rd_rec = mem_q[rd_ptr_q];
    end

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    state_d     = W0;
                    out_data_d  = rd_rec.pc;
                    out_last_d  = 1'b0;
                    hold_addr_d = rd_rec.addr;
                    hold_data_d = rd_rec.data;
                end
            end
            W0: begin
                if (bus.out_ready) begin
                    state_d    = W1;
                    out_data_d = {27'b0, hold_addr_q};
                end
            end
            W1: begin
                if (bus.out_ready) begin
                    state_d    = W2;
                    out_data_d = hold_data_q;
                    out_last_d = 1'b1;
                end
            end
            W2: begin
                if (bus.out_ready) begin
                    out_last_d = 1'b0;
                    if (!empty) begin
                        // Chain straight into the next record so a busy FIFO drains without bubbles.
                        pop         = 1'b1;
                        state_d     = W0;
                        out_data_d  = rd_rec.pc;
                        hold_addr_d = rd_rec.addr;
                        hold_data_d = rd_rec.data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    // NOTE: the record storage has no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (reset && push) mem_q[wr_ptr_q] <= wr_rec;
    end

    assign bus.out_valid = (state_q != IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign fifo_count    = count_q;
    assign drop_cnt      = drop_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: a per-cycle vector table plus hand-written sequences
// for overflow, reset mid-record and simultaneous push/pop.
module tb_wb_trace_fifo;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [4:0]        fifo_count;
    logic [DROP_W-1:0] drop_cnt;
    logic              overflow;

    wb_trace_fifo_if bus ();

    wb_trace_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] pc;
        logic [31:0] data;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
        logic [4:0]  e_count;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs [15];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [4:0] addr, input logic [31:0] pc,
                         input logic [31:0] data, input logic rdy);
        bus.wb_en     = en;
        bus.wb_addr   = addr;
        bus.wb_pc     = pc;
        bus.wb_data   = data;
        bus.out_ready = rdy;
    endtask

    function automatic logic [31:0] pc_of(input int k);
        return 32'h0000_1000 + 32'(k) * 32'd4;
    endfunction

    function automatic logic [31:0] data_of(input int k);
        return 32'hD000_0000 | 32'(k);
    endfunction

    // One event per cycle with the consumer stalled, addresses first..first+n-1.
    task automatic push_events(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 5'(first + i), pc_of(first + i), data_of(first + i), 1'b0);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    logic [31:0] wq [$];
    logic        lq [$];

    initial begin
        // Single record, zero-register filter, then a record under toggling backpressure.
        vecs[0]  = '{1'b1, 5'd8, 32'h0000_3000, 32'h1234_5678, 1'b1, 1'b0, 32'h0,          1'b0, 5'd1, 16'd0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_3000, 1'b0, 5'd0, 16'd0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_0008, 1'b0, 5'd0, 16'd0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h1234_5678, 1'b1, 5'd0, 16'd0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,          1'b0, 5'd0, 16'd0};
        vecs[5]  = '{1'b1, 5'd0, 32'h0000_0BAD, 32'h0000_0BAD, 1'b1, 1'b0, 32'h0,          1'b0, 5'd0, 16'd0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,          1'b0, 5'd0, 16'd0};
        vecs[7]  = '{1'b1, 5'd5, 32'h0000_0100, 32'hAAAA_5555, 1'b0, 1'b0, 32'h0,          1'b0, 5'd1, 16'd0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b0, 5'd0, 16'd0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b0, 5'd0, 16'd0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_0005, 1'b0, 5'd0, 16'd0};
        vecs[11] = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0005, 1'b0, 5'd0, 16'd0};
        vecs[12] = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 1'b1, 32'hAAAA_5555, 1'b1, 5'd0, 16'd0};
        vecs[13] = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b1, 32'hAAAA_5555, 1'b1, 5'd0, 16'd0};
        vecs[14] = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,          1'b0, 5'd0, 16'd0};

        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_last",  bus.out_last, 0);
        check("rst_data",  bus.out_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_drop",  drop_cnt, 0);
        check("rst_ovf",   overflow, 0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].en, vecs[i].addr, vecs[i].pc, vecs[i].data, vecs[i].rdy);
            tick();
            check($sformatf("v%0d_valid", i), bus.out_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) check($sformatf("v%0d_data", i), bus.out_data, vecs[i].e_data);
            check($sformatf("v%0d_last", i),  bus.out_last, vecs[i].e_last);
            check($sformatf("v%0d_count", i), fifo_count, vecs[i].e_count);
            check($sformatf("v%0d_drop", i),  drop_cnt, vecs[i].e_drop);
        end

        // Overflow: 20 events against a stalled consumer.
        push_events(1, 20);
        check("ovf_count", fifo_count, 16);
        check("ovf_drop",  drop_cnt, 3);
        check("ovf_flag",  overflow, 1);
        check("ovf_valid", bus.out_valid, 1);
        check("ovf_head",  bus.out_data, pc_of(1));

        bus.out_ready = 1'b1;
        for (int c = 0; c < 200 && wq.size() < 51; c++) begin
            if (bus.out_valid) begin
                wq.push_back(bus.out_data);
                lq.push_back(bus.out_last);
            end
            tick();
        end
        check("ovf_words", wq.size(), 51);
        if (wq.size() == 51) begin
            for (int r = 0; r < 17; r++) begin
                check($sformatf("ovf_r%0d_pc", r + 1),   wq[3*r],     pc_of(r + 1));
                check($sformatf("ovf_r%0d_addr", r + 1), wq[3*r + 1], 32'(r + 1));
                check($sformatf("ovf_r%0d_data", r + 1), wq[3*r + 2], data_of(r + 1));
                check($sformatf("ovf_r%0d_last", r + 1), {lq[3*r], lq[3*r + 1], lq[3*r + 2]}, 3'b001);
            end
        end
        check("ovf_end_count", fifo_count, 0);
        check("ovf_end_valid", bus.out_valid, 0);
        check("ovf_sticky",    overflow, 1);

        // Reset in W1 with four records queued; drop state from the overflow run is still set.
        push_events(26, 5);
        check("rmid_count", fifo_count, 4);
        bus.out_ready = 1'b1;
        tick();
        check("rmid_w1", bus.out_data, 26);
        reset = 1'b0;
        drive(1'b1, 5'd31, pc_of(31), data_of(31), 1'b1);
        tick();
        check("rmid_valid", bus.out_valid, 0);
        check("rmid_count0", fifo_count, 0);
        check("rmid_drop", drop_cnt, 0);
        check("rmid_ovf", overflow, 0);
        check("rmid_data", bus.out_data, 0);
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        tick();
        check("rmid_noreplay_valid", bus.out_valid, 0);
        check("rmid_noreplay_count", fifo_count, 0);
        drive(1'b1, 5'd9, 32'h0000_4000, 32'hCAFE_BABE, 1'b1);
        tick();
        check("fresh_count", fifo_count, 1);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        tick();
        check("fresh_w0", bus.out_data, 32'h0000_4000);
        tick();
        check("fresh_w1", bus.out_data, 32'h0000_0009);
        tick();
        check("fresh_w2", bus.out_data, 32'hCAFE_BABE);
        check("fresh_last", bus.out_last, 1);
        tick();
        check("fresh_idle", bus.out_valid, 0);

        // Push and pop in the same cycle as a W2 handshake.
        push_events(21, 4);
        check("sim_count_pre", fifo_count, 3);
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("sim_w2_last", bus.out_last, 1);
        check("sim_w2_data", bus.out_data, data_of(21));
        drive(1'b1, 5'd25, pc_of(25), data_of(25), 1'b1);
        tick();
        check("sim_count_post", fifo_count, 3);
        check("sim_b2b_valid", bus.out_valid, 1);
        check("sim_b2b_pc", bus.out_data, pc_of(22));
        check("sim_b2b_last", bus.out_last, 0);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        wq.delete();
        for (int c = 0; c < 12; c++) begin
            check($sformatf("sim_stream_valid%0d", c), bus.out_valid, 1);
            wq.push_back(bus.out_data);
            tick();
        end
        check("sim_order0", wq[1],  22);
        check("sim_order1", wq[4],  23);
        check("sim_order2", wq[7],  24);
        check("sim_order3", wq[10], 25);
        check("sim_new_data", wq[11], data_of(25));
        check("sim_end_valid", bus.out_valid, 0);
        check("sim_end_count", fifo_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
